// File: rtl/pwm_av_pkg.sv
// Shared constants for the PWM Avalon key block: the register map
// addresses, the edge-capture mode encodings, and the per-bit edge qualifier.
package pwm_av_pkg;

    // Avalon-MM word addresses of the four registers
    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    // Edge-capture modes selected by the EDGE_TYPE parameter
    localparam int EDGE_FALL = 0;
    localparam int EDGE_RISE = 1;
    localparam int EDGE_ANY  = 2;

    // True when the prev -> cur transition of one debounced bit qualifies
    // as an edge under the given mode. Any unknown mode behaves as "any".
    function automatic logic edge_hit(input logic prev, input logic cur, input int mode);
        case (mode)
            EDGE_FALL: return prev & ~cur;
            EDGE_RISE: return ~prev & cur;
            default:   return prev ^ cur;
        endcase
    endfunction

endpackage

// File: rtl/pwm_av_keys_debounce.sv
// One key bit: 2-flop synchronizer followed by a saturating-free debounce
// counter. The stable level only moves after the synchronized input has
// disagreed with it for DEBOUNCE_CYCLES consecutive clocks.
module pwm_av_keys_debounce
    import pwm_av_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic stable
);

    // Counter only ever holds 0..DEBOUNCE_CYCLES-1, so clog2 bits never wrap.
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic [CW-1:0] count;
    logic          stable_q;

    // Two-flop synchronizer; resets to the idle (released) key level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
        end
    end

    // Count disagreement clocks; accept the new level on the last one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count    <= '0;
            stable_q <= 1'b1;
        end else if (sync_q2 == stable_q) begin
            count <= '0;
        end else if (count == LAST) begin
            stable_q <= sync_q2;
            count    <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/pwm_av_keys.sv
// Debounced key input port with Avalon-MM slave registers: data (RO),
// irqmask (RW) and edgecapture (RW1C), plus a level interrupt.
//
// Bus timing: reads are zero-wait-state, readdata follows address
// combinationally whether or not chipselect is high; a write is accepted on
// the clk edge where chipselect=1 and write_n=0, with no back-pressure.
module pwm_av_keys
    import pwm_av_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_prev;
    logic [WIDTH-1:0] edge_hits;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecap;
    logic             wr_en;
    logic             unused_wdata;

    // Only the low WIDTH bits of writedata are meaningful.
    assign unused_wdata = ^writedata;
    assign wr_en        = chipselect & ~write_n;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_key
            pwm_av_keys_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk    (clk),
                .reset_n(reset_n),
                .raw    (in_port[gi]),
                .stable (stable[gi])
            );
        end
    endgenerate

    // Previous-cycle copy of the debounced keys, idle-high out of reset so
    // that releasing reset with keys up produces no edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_prev <= '1;
        end else begin
            stable_prev <= stable;
        end
    end

    // Qualify each bit's transition according to the selected edge mode.
    always_comb begin
        edge_hits = '0;
        for (int i = 0; i < WIDTH; i++) begin
            edge_hits[i] = edge_hit(stable_prev[i], stable[i], EDGE_TYPE);
        end
    end

    // Interrupt mask register, loaded from the low bits of a write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask <= '0;
        end else if (wr_en && address == ADDR_IRQMASK) begin
            irqmask <= writedata[WIDTH-1:0];
        end
    end

    // Edge capture: write-1-to-clear, with a new edge in the same cycle
    // taking priority over the clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edgecap <= '0;
        end else if (wr_en && address == ADDR_EDGECAP) begin
            edgecap <= (edgecap & ~writedata[WIDTH-1:0]) | edge_hits;
        end else begin
            edgecap <= edgecap | edge_hits;
        end
    end

    // Read mux, zero-extended above WIDTH; the reserved word reads zero.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata[WIDTH-1:0] = stable;
            ADDR_RSVD:    readdata = '0;
            ADDR_IRQMASK: readdata[WIDTH-1:0] = irqmask;
            ADDR_EDGECAP: readdata[WIDTH-1:0] = edgecap;
            default:      readdata = '0;
        endcase
    end

    assign irq = |(edgecap & irqmask);

endmodule
